event_capture_nch: RTL and testbench

EVENT_CAPTURE_NCH -- requirements
Module: event_capture_nch

---
 rtl/qpix_evt_pkg.sv | 20 ++
 rtl/event_capture_nch_ts_fifo.sv | 67 ++++++
 rtl/event_capture_nch.sv | 137 +++++++++++++
 tb/tb_event_capture_nch.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qpix_evt_pkg.sv
`default_nettype none
// ============================================================================
//  Package : qpix_evt_pkg
//  Shared defaults for the multi-channel event timestamp capture block.
//  Revision: 1.0
// ============================================================================
package qpix_evt_pkg;

   localparam int c_nch   = 16;
   localparam int c_ts_w  = 32;
   localparam int c_depth = 16;
   localparam int c_sel_w = 5;

   // Rising edges on a vector given the current and previous samples.
   function automatic logic [31:0] rise_vec(input logic [31:0] cur, input logic [31:0] prev);
      return cur & ~prev;
   endfunction

endpackage : qpix_evt_pkg
`default_nettype wire

// File: rtl/event_capture_nch_ts_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : ts_fifo
//  Single-clock timestamp FIFO with head-of-queue output (no fall-through).
//  Revision: 1.0
// ============================================================================
module ts_fifo
   import qpix_evt_pkg::*;
#(
   parameter int TS_W  = c_ts_w,
   parameter int DEPTH = c_depth
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            wr,
   input  logic [TS_W-1:0] din,
   input  logic            rd,
   output logic [TS_W-1:0] dout,
   output logic            empty,
   output logic            full
);

   localparam int          c_aw   = $clog2(DEPTH);
   localparam logic [c_aw:0] c_full = DEPTH[c_aw:0];

   logic [TS_W-1:0] r_mem [DEPTH];
   logic [c_aw-1:0] r_wr_ptr;
   logic [c_aw-1:0] r_rd_ptr;
   logic [c_aw:0]   r_count;
   logic            w_do_wr;
   logic            w_do_rd;

   assign empty   = (r_count == '0);
   assign full    = (r_count == c_full);
   assign w_do_wr = wr & ~full;
   assign w_do_rd = rd & ~empty;
   assign dout    = r_mem[r_rd_ptr];

   // Storage is not reset; pointers and occupancy alone define the contents.
   always_ff @(posedge clk) begin
      if (w_do_wr) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_wr) begin
            r_wr_ptr <= r_wr_ptr + c_aw'(1);
         end
         if (w_do_rd) begin
            r_rd_ptr <= r_rd_ptr + c_aw'(1);
         end
         case ({w_do_wr, w_do_rd})
            2'b10:   r_count <= r_count + (c_aw+1)'(1);
            2'b01:   r_count <= r_count - (c_aw+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule : ts_fifo
`default_nettype wire

// File: rtl/event_capture_nch.sv
`default_nettype none
// ============================================================================
//  Module  : event_capture_nch
//  Timestamps synchronised event edges into per-channel FIFOs with a read port.
//  Revision: 1.0
// ============================================================================
module event_capture_nch
   import qpix_evt_pkg::*;
#(
   parameter int NCH   = c_nch,
   parameter int TS_W  = c_ts_w,
   parameter int DEPTH = c_depth
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic [NCH-1:0]     ev_in,
   input  logic               trigger,
   input  logic [c_sel_w-1:0] rd_sel,
   input  logic               rd_req,
   input  logic               clr_ovf,
   output logic [TS_W-1:0]    rd_data,
   output logic               rd_valid,
   output logic               rd_err,
   output logic [NCH-1:0]     empty,
   output logic [NCH-1:0]     full,
   output logic [NCH-1:0]     ovf
);

   logic [NCH-1:0]  r_sync1;
   logic [NCH-1:0]  r_sync2;
   logic [NCH-1:0]  r_ev_prev;
   logic [1:0]      r_warm;
   logic            r_trig_prev;
   logic            r_rd_req_prev;
   logic [TS_W-1:0] r_ts;
   logic [NCH-1:0]  r_ovf;

   logic            w_armed;
   logic            w_live;
   logic [31:0]     w_rise_raw;
   logic [NCH-1:0]  w_rise;
   logic [NCH-1:0]  w_wr;
   logic [NCH-1:0]  w_drop;
   logic [NCH-1:0]  w_fifo_rd;
   logic [TS_W-1:0] w_dout [NCH];
   logic [TS_W-1:0] w_head;
   logic            w_head_empty;
   logic            w_pop;
   logic            w_pop_ok;

   // Edge detectors are masked until the synchroniser pipe holds real samples,
   // so a level already high at reset release is not seen as an edge.
   assign w_armed    = (r_warm == 2'd3);
   assign w_live     = (r_warm != 2'd0);
   assign w_rise_raw = rise_vec(32'(r_sync2), 32'(r_ev_prev));
   assign w_rise     = w_rise_raw[NCH-1:0] & {NCH{w_armed}};
   assign w_pop      = rd_req & ~r_rd_req_prev & w_live;
   assign w_pop_ok   = w_pop & ~w_head_empty;
   assign ovf        = r_ovf;

   always_comb begin
      w_head       = '0;
      w_head_empty = 1'b1;
      for (int i = 0; i < NCH; i++) begin
         if (rd_sel == c_sel_w'(i)) begin
            w_head       = w_dout[i];
            w_head_empty = empty[i];
         end
      end
   end

   // Full is judged on pre-read occupancy, so a same-cycle pop never makes room.
   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_ch
         assign w_wr[gi]      = w_rise[gi] & trigger & ~full[gi];
         assign w_drop[gi]    = w_rise[gi] & trigger &  full[gi];
         assign w_fifo_rd[gi] = w_pop_ok & (rd_sel == c_sel_w'(gi));

         ts_fifo #(
            .TS_W  (TS_W),
            .DEPTH (DEPTH)
         ) u_fifo (
            .clk    (clk),
            .resetn (resetn),
            .wr     (w_wr[gi]),
            .din    (r_ts),
            .rd     (w_fifo_rd[gi]),
            .dout   (w_dout[gi]),
            .empty  (empty[gi]),
            .full   (full[gi])
         );
      end
   endgenerate

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_sync1       <= '0;
         r_sync2       <= '0;
         r_ev_prev     <= '0;
         r_warm        <= 2'd0;
         r_trig_prev   <= 1'b0;
         r_rd_req_prev <= 1'b0;
         r_ts          <= '0;
         r_ovf         <= '0;
         rd_data       <= '0;
         rd_valid      <= 1'b0;
         rd_err        <= 1'b0;
      end else begin
         r_sync1       <= ev_in;
         r_sync2       <= r_sync1;
         r_ev_prev     <= r_sync2;
         r_trig_prev   <= trigger;
         r_rd_req_prev <= rd_req;
         if (!w_armed) begin
            r_warm <= r_warm + 2'd1;
         end

         if (trigger && !r_trig_prev) begin
            r_ts <= '0;
         end else if (trigger) begin
            r_ts <= r_ts + TS_W'(1);
         end

         // A drop in the clearing cycle wins, keeping the flag set.
         r_ovf <= (r_ovf & ~{NCH{clr_ovf}}) | w_drop;

         rd_valid <= w_pop_ok;
         rd_err   <= w_pop & w_head_empty;
         if (w_pop_ok) begin
            rd_data <= w_head;
         end
      end
   end

endmodule : event_capture_nch
`default_nettype wire

// File: tb/tb_event_capture_nch.sv
`default_nettype none
// ============================================================================
//  Module  : tb_event_capture_nch
//  Directed scoreboard bench for event_capture_nch (default and TS_W=8 builds).
//  Revision: 1.0
// ============================================================================
module tb_event_capture_nch;

   logic        clk;
   logic        resetn;
   logic [15:0] ev_in;
   logic        trigger;
   logic [4:0]  rd_sel;
   logic        rd_req;
   logic        clr_ovf;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        rd_err;
   logic [15:0] empty;
   logic [15:0] full;
   logic [15:0] ovf;

   logic [15:0] ev8;
   logic        trigger8;
   logic [4:0]  rd_sel8;
   logic        rd_req8;
   logic        clr8;
   logic [7:0]  rd_data8;
   logic        rd_valid8;
   logic        rd_err8;
   logic [15:0] empty8;
   logic [15:0] full8;
   logic [15:0] ovf8;

   int          total;
   int          bad;
   int          cyc;
   int          trig_cyc;
   int          trig8;
   logic [31:0] exp_q [16][$];
   logic [31:0] last_data;

   event_capture_nch dut (
      .clk      (clk),
      .resetn   (resetn),
      .ev_in    (ev_in),
      .trigger  (trigger),
      .rd_sel   (rd_sel),
      .rd_req   (rd_req),
      .clr_ovf  (clr_ovf),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .rd_err   (rd_err),
      .empty    (empty),
      .full     (full),
      .ovf      (ovf)
   );

   event_capture_nch #(.NCH(16), .TS_W(8), .DEPTH(16)) dut8 (
      .clk      (clk),
      .resetn   (resetn),
      .ev_in    (ev8),
      .trigger  (trigger8),
      .rd_sel   (rd_sel8),
      .rd_req   (rd_req8),
      .clr_ovf  (clr8),
      .rd_data  (rd_data8),
      .rd_valid (rd_valid8),
      .rd_err   (rd_err8),
      .empty    (empty8),
      .full     (full8),
      .ovf      (ovf8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic start_trigger();
      trigger  = 1'b1;
      trig_cyc = cyc + 1;
      tick(2);
   endtask

   // Edge-detect cycle sits two clocks after the input is driven.
   task automatic pulse(input logic [15:0] m, input bit record);
      logic [31:0] ts;
      ts    = 32'(cyc + 2 - trig_cyc);
      ev_in = m;
      if (record) begin
         for (int c = 0; c < 16; c++) begin
            if (m[c]) exp_q[c].push_back(ts);
         end
      end
      tick(2);
      ev_in = '0;
      tick(2);
   endtask

   task automatic do_pop(input logic [4:0] sel, input bit ok, input string tag,
                         output logic [31:0] got);
      logic [31:0] exp;
      rd_sel = sel;
      rd_req = 1'b1;
      tick(1);
      got = rd_data;
      if (ok) begin
         if (exp_q[sel].size() == 0) begin
            exp = 32'hDEAD_BEEF;
         end else begin
            exp = exp_q[sel].pop_front();
         end
         chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
         chk({tag, "_err"},   32'(rd_err),   32'd0);
         chk({tag, "_data"},  rd_data,       exp);
         last_data = exp;
      end else begin
         chk({tag, "_err"},   32'(rd_err),   32'd1);
         chk({tag, "_valid"}, 32'(rd_valid), 32'd0);
         chk({tag, "_hold"},  rd_data,       last_data);
      end
      rd_req = 1'b0;
      tick(1);
      chk({tag, "_strobe"}, 32'({rd_valid, rd_err}), 32'd0);
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] b;
      total     = 0;
      bad       = 0;
      cyc       = 0;
      last_data = '0;
      resetn    = 1'b0;
      ev_in     = '0;
      trigger   = 1'b0;
      rd_sel    = '0;
      rd_req    = 1'b0;
      clr_ovf   = 1'b0;
      ev8       = '0;
      trigger8  = 1'b0;
      rd_sel8   = '0;
      rd_req8   = 1'b0;
      clr8      = 1'b0;
      tick(3);

      chk("rst_empty",  32'(empty), 32'h0000_FFFF);
      chk("rst_full",   32'(full),  32'd0);
      chk("rst_ovf",    32'(ovf),   32'd0);
      chk("rst_strobe", 32'({rd_valid, rd_err}), 32'd0);
      chk("rst_data",   rd_data,    32'd0);
      resetn = 1'b1;
      tick(5);
      start_trigger();

      // two events 25 cycles apart on channel 0
      pulse(16'h0001, 1'b1);
      tick(21);
      pulse(16'h0001, 1'b1);
      chk("t1_nonempty", 32'(empty[0]), 32'd0);
      do_pop(5'd0, 1'b1, "t1_pop0", a);
      do_pop(5'd0, 1'b1, "t1_pop1", b);
      chk("t1_delta", b - a, 32'd25);
      do_pop(5'd0, 1'b0, "t1_pop_empty", a);

      // simultaneous events on channels 0 and 15
      pulse(16'h8001, 1'b1);
      chk("t2_occ", 32'({empty[15], empty[0]}), 32'd0);
      do_pop(5'd0,  1'b1, "t2_ch0",  a);
      do_pop(5'd15, 1'b1, "t2_ch15", b);
      chk("t2_same_ts", a, b);
      chk("t2_drained", 32'(empty), 32'h0000_FFFF);

      // overflow on channel 3: only the first 16 are kept
      for (int k = 0; k < 18; k++) pulse(16'h0008, (k < 16));
      chk("t3_full", 32'(full), 32'h0000_0008);
      chk("t3_ovf",  32'(ovf),  32'h0000_0008);
      for (int k = 0; k < 16; k++) do_pop(5'd3, 1'b1, $sformatf("t3_pop%0d", k), a);
      do_pop(5'd3, 1'b0, "t3_underrun", a);
      chk("t3_ovf_sticky", 32'(ovf), 32'h0000_0008);
      clr_ovf = 1'b1;
      tick(1);
      clr_ovf = 1'b0;
      tick(1);
      chk("t3_ovf_clr", 32'(ovf), 32'd0);

      // write and pop to empty channel 5 on the same clock: error, word kept
      exp_q[5].push_back(32'(cyc + 2 - trig_cyc));
      ev_in  = 16'h0020;
      rd_sel = 5'd5;
      tick(2);
      ev_in  = '0;
      rd_req = 1'b1;
      tick(1);
      chk("t4_err",   32'({rd_valid, rd_err}), 32'd1);
      chk("t4_kept",  32'(empty[5]), 32'd0);
      rd_req = 1'b0;
      tick(2);
      do_pop(5'd5, 1'b1, "t4_pop", a);

      // invalid channel selects
      do_pop(5'd16, 1'b0, "t5_sel16", a);
      do_pop(5'd31, 1'b0, "t5_sel31", a);

      // events ignored while trigger is low
      trigger = 1'b0;
      tick(2);
      pulse(16'h0002, 1'b0);
      chk("t6_empty1", 32'(empty[1]), 32'd1);
      chk("t6_ovf",    32'(ovf),      32'd0);
      start_trigger();

      // reset with 5 words in channel 2; high ev_in/rd_req across release
      for (int k = 0; k < 5; k++) pulse(16'h0004, 1'b1);
      chk("t7_loaded", 32'(empty[2]), 32'd0);
      ev_in  = 16'h0010;
      rd_sel = 5'd2;
      rd_req = 1'b1;
      resetn = 1'b0;
      tick(1);
      chk("t7_in_rst_empty", 32'(empty), 32'h0000_FFFF);
      chk("t7_in_rst_full",  32'(full),  32'd0);
      tick(1);
      resetn = 1'b1;
      exp_q[2].delete();
      last_data = '0;
      for (int k = 0; k < 6; k++) begin
         tick(1);
         chk($sformatf("t7_no_spurious%0d", k), 32'({rd_valid, rd_err}), 32'd0);
      end
      chk("t7_no_ev4", 32'(empty[4]), 32'd1);
      ev_in  = '0;
      rd_req = 1'b0;
      tick(2);
      do_pop(5'd2, 1'b0, "t7_pop_after_rst", a);

      // TS_W=8: events at counted cycles 250 and 260 store 250 and 4
      trigger8 = 1'b1;
      trig8    = cyc + 1;
      tick(249);
      ev8 = 16'h0001;
      tick(2);
      ev8 = '0;
      tick(8);
      ev8 = 16'h0001;
      tick(2);
      ev8 = '0;
      tick(40);
      rd_sel8 = 5'd0;
      rd_req8 = 1'b1;
      tick(1);
      chk("t8_v0",    32'(rd_valid8), 32'd1);
      chk("t8_ts250", 32'(rd_data8),  32'd250);
      rd_req8 = 1'b0;
      tick(1);
      rd_req8 = 1'b1;
      tick(1);
      chk("t8_v1",    32'(rd_valid8), 32'd1);
      chk("t8_ts4",   32'(rd_data8),  32'd4);
      rd_req8 = 1'b0;
      tick(1);
      chk("t8_drained", 32'(empty8[0]), 32'd1);
      chk("t8_base_ts", 32'(trig8 - trig8), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_event_capture_nch
`default_nettype wire
